// File: rtl/core_tile_pkg.sv
// Shared types and constants for the rotate-engine tile address generator.
// Imported by the address generator top and its source-mapping sub-block.
package core_tile_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROTATE = 2'd2,
        STORE  = 2'd3
    } state_t;

    localparam logic [1:0] DEG_0   = 2'd0;
    localparam logic [1:0] DEG_90  = 2'd1;
    localparam logic [1:0] DEG_180 = 2'd2;
    localparam logic [1:0] DEG_270 = 2'd3;

    localparam int CH_B = 0;
    localparam int CH_G = 1;
    localparam int CH_R = 2;

    // Counter-clockwise turns become the complementary clockwise turn.
    function automatic logic [1:0] eff_rot(input logic [1:0] deg,
                                           input logic       cw);
        return cw ? deg : (2'd0 - deg);
    endfunction

endpackage

// File: rtl/core_tile_src_map.sv
// Maps an output raster position and clockwise rotation to the
// source pixel index inside a square tile.
module core_tile_src_map
    import core_tile_pkg::*;
#(
    parameter int TILE_DIM = 8,
    parameter int CNT_W    = 3,
    parameter int IDX_W    = 9
) (
    input  logic [CNT_W-1:0] row,
    input  logic [CNT_W-1:0] col,
    input  logic [1:0]       rot,
    output logic [IDX_W-1:0] src_idx
);

    logic [IDX_W-1:0] r_e;
    logic [IDX_W-1:0] c_e;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] sr;
    logic [IDX_W-1:0] sc;

    // Pick the source row/column for the requested quarter turn.
    always_comb begin
        r_e  = IDX_W'(row);
        c_e  = IDX_W'(col);
        last = IDX_W'(TILE_DIM - 1);
        sr   = r_e;
        sc   = c_e;
        unique case (rot)
            DEG_0: begin
                sr = r_e;
                sc = c_e;
            end
            DEG_90: begin
                sr = last - c_e;
                sc = r_e;
            end
            DEG_180: begin
                sr = last - r_e;
                sc = last - c_e;
            end
            DEG_270: begin
                sr = c_e;
                sc = last - r_e;
            end
        endcase
        src_idx = sr * IDX_W'(TILE_DIM) + sc;
    end

endmodule

// File: rtl/core_tile_agen.sv
// Tile address generator: bus-word loads, rotated per-pixel channel
// addresses, then bus-word stores, each with valid/ready backpressure.
module core_tile_agen
    import core_tile_pkg::*;
#(
    parameter int TILE_DIM  = 8,
    parameter int BPP       = 3,
    parameter int BUS_BYTES = 4,
    parameter int ADDR_W    = 8
) (
    input  logic                  I_TA_HCLK,
    input  logic                  I_TA_HRESET_N,
    input  logic                  I_TA_START,
    input  logic                  I_TA_STOP,
    input  logic [1:0]            I_TA_DEGREES,
    input  logic                  I_TA_DIRECTION,
    output logic                  O_TA_LOAD_VALID,
    input  logic                  I_TA_LOAD_READY,
    output logic [ADDR_W-1:0]     O_TA_LOAD_ADDR,
    output logic                  O_TA_PIX_VALID,
    input  logic                  I_TA_PIX_READY,
    output logic [BPP*ADDR_W-1:0] O_TA_PIX_SRC_ADDR,
    output logic [BPP*ADDR_W-1:0] O_TA_PIX_DST_ADDR,
    output logic                  O_TA_STORE_VALID,
    input  logic                  I_TA_STORE_READY,
    output logic [ADDR_W-1:0]     O_TA_STORE_ADDR,
    output logic                  O_TA_BUSY,
    output logic                  O_TA_DONE
);

    localparam int AW1   = ADDR_W + 1;
    localparam int CW    = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
    localparam int BEATS = TILE_DIM * TILE_DIM * BPP / BUS_BYTES;

    localparam logic [AW1-1:0] LAST_BEAT = AW1'(BEATS - 1);
    localparam logic [CW-1:0]  LAST_RC   = CW'(TILE_DIM - 1);

    if (TILE_DIM * TILE_DIM * BPP > (1 << ADDR_W)) begin : g_size_chk
        $error("core_tile_agen: tile does not fit in ADDR_W");
    end
    if ((TILE_DIM * TILE_DIM * BPP) % BUS_BYTES != 0) begin : g_bus_chk
        $error("core_tile_agen: tile bytes not a multiple of BUS_BYTES");
    end

    state_t           state;
    state_t           state_nxt;
    logic [AW1-1:0]   beat;
    logic [AW1-1:0]   beat_nxt;
    logic [CW-1:0]    row;
    logic [CW-1:0]    row_nxt;
    logic [CW-1:0]    col;
    logic [CW-1:0]    col_nxt;
    logic [1:0]       rot;
    logic [1:0]       rot_nxt;
    logic             done_nxt;
    logic [AW1-1:0]   src_idx;
    logic [AW1-1:0]   dst_idx;
    logic [AW1-1:0]   src_base;
    logic [AW1-1:0]   dst_base;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] src_ch [BPP];
    logic [ADDR_W-1:0] dst_ch [BPP];

    core_tile_src_map #(
        .TILE_DIM (TILE_DIM),
        .CNT_W    (CW),
        .IDX_W    (AW1)
    ) u_src_map (
        .row     (row_nxt),
        .col     (col_nxt),
        .rot     (rot_nxt),
        .src_idx (src_idx)
    );

    assign dst_idx   = AW1'(row_nxt) * AW1'(TILE_DIM) + AW1'(col_nxt);
    assign src_base  = src_idx * AW1'(BPP);
    assign dst_base  = dst_idx * AW1'(BPP);
    assign word_addr = ADDR_W'(beat_nxt * AW1'(BUS_BYTES));

    for (genvar g = 0; g < BPP; g++) begin : g_ch
        assign src_ch[g] = ADDR_W'(src_base + AW1'(g));
        assign dst_ch[g] = ADDR_W'(dst_base + AW1'(g));
    end

    // Phase and counter register.
    always_ff @(posedge I_TA_HCLK or negedge I_TA_HRESET_N) begin
        if (!I_TA_HRESET_N) begin
            state <= IDLE;
            beat  <= '0;
            row   <= '0;
            col   <= '0;
            rot   <= DEG_0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            rot   <= rot_nxt;
        end
    end

    // Next phase and counters; abort overrides everything.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        row_nxt   = row;
        col_nxt   = col;
        rot_nxt   = rot;
        done_nxt  = 1'b0;
        if (I_TA_STOP) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            row_nxt   = '0;
            col_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (I_TA_START) begin
                        state_nxt = LOAD;
                        beat_nxt  = '0;
                        rot_nxt   = eff_rot(I_TA_DEGREES, I_TA_DIRECTION);
                    end
                end
                LOAD: begin
                    if (I_TA_LOAD_READY) begin
                        if (beat == LAST_BEAT) begin
                            state_nxt = ROTATE;
                            beat_nxt  = '0;
                        end else begin
                            beat_nxt = beat + AW1'(1);
                        end
                    end
                end
                ROTATE: begin
                    if (I_TA_PIX_READY) begin
                        if (col == LAST_RC) begin
                            col_nxt = '0;
                            if (row == LAST_RC) begin
                                row_nxt   = '0;
                                state_nxt = STORE;
                            end else begin
                                row_nxt = row + CW'(1);
                            end
                        end else begin
                            col_nxt = col + CW'(1);
                        end
                    end
                end
                STORE: begin
                    if (I_TA_STORE_READY) begin
                        if (beat == LAST_BEAT) begin
                            state_nxt = IDLE;
                            beat_nxt  = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            beat_nxt = beat + AW1'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Registered stream outputs; an inactive stream shows zero address.
    always_ff @(posedge I_TA_HCLK or negedge I_TA_HRESET_N) begin
        if (!I_TA_HRESET_N) begin
            O_TA_LOAD_VALID   <= 1'b0;
            O_TA_LOAD_ADDR    <= '0;
            O_TA_PIX_VALID    <= 1'b0;
            O_TA_PIX_SRC_ADDR <= '0;
            O_TA_PIX_DST_ADDR <= '0;
            O_TA_STORE_VALID  <= 1'b0;
            O_TA_STORE_ADDR   <= '0;
            O_TA_BUSY         <= 1'b0;
            O_TA_DONE         <= 1'b0;
        end else begin
            O_TA_LOAD_VALID  <= (state_nxt == LOAD);
            O_TA_LOAD_ADDR   <= (state_nxt == LOAD) ? word_addr : '0;
            O_TA_PIX_VALID   <= (state_nxt == ROTATE);
            O_TA_STORE_VALID <= (state_nxt == STORE);
            O_TA_STORE_ADDR  <= (state_nxt == STORE) ? word_addr : '0;
            O_TA_BUSY        <= (state_nxt != IDLE);
            O_TA_DONE        <= done_nxt;
            for (int ch = 0; ch < BPP; ch++) begin
                O_TA_PIX_SRC_ADDR[ch*ADDR_W +: ADDR_W] <=
                    (state_nxt == ROTATE) ? src_ch[ch] : '0;
                O_TA_PIX_DST_ADDR[ch*ADDR_W +: ADDR_W] <=
                    (state_nxt == ROTATE) ? dst_ch[ch] : '0;
            end
        end
    end

endmodule

// File: tb/tb_core_tile_agen.sv
// Self-checking bench for core_tile_agen: directed tiles with random
// backpressure, checked against an image-rotation reference model.
module tb_core_tile_agen;

    localparam int N     = 8;
    localparam int BPP   = 3;
    localparam int BUS   = 4;
    localparam int AW    = 8;
    localparam int BEATS = 48;
    localparam int NPIX  = 64;

    logic              I_TA_HCLK = 1'b0;
    logic              I_TA_HRESET_N;
    logic              I_TA_START;
    logic              I_TA_STOP;
    logic [1:0]        I_TA_DEGREES;
    logic              I_TA_DIRECTION;
    logic              O_TA_LOAD_VALID;
    logic              I_TA_LOAD_READY;
    logic [AW-1:0]     O_TA_LOAD_ADDR;
    logic              O_TA_PIX_VALID;
    logic              I_TA_PIX_READY;
    logic [BPP*AW-1:0] O_TA_PIX_SRC_ADDR;
    logic [BPP*AW-1:0] O_TA_PIX_DST_ADDR;
    logic              O_TA_STORE_VALID;
    logic              I_TA_STORE_READY;
    logic [AW-1:0]     O_TA_STORE_ADDR;
    logic              O_TA_BUSY;
    logic              O_TA_DONE;

    int checks = 0;
    int errors = 0;
    int img [N][N];
    int first_src [NPIX];

    always #5 I_TA_HCLK = ~I_TA_HCLK;

    core_tile_agen dut (
        .I_TA_HCLK         (I_TA_HCLK),
        .I_TA_HRESET_N     (I_TA_HRESET_N),
        .I_TA_START        (I_TA_START),
        .I_TA_STOP         (I_TA_STOP),
        .I_TA_DEGREES      (I_TA_DEGREES),
        .I_TA_DIRECTION    (I_TA_DIRECTION),
        .O_TA_LOAD_VALID   (O_TA_LOAD_VALID),
        .I_TA_LOAD_READY   (I_TA_LOAD_READY),
        .O_TA_LOAD_ADDR    (O_TA_LOAD_ADDR),
        .O_TA_PIX_VALID    (O_TA_PIX_VALID),
        .I_TA_PIX_READY    (I_TA_PIX_READY),
        .O_TA_PIX_SRC_ADDR (O_TA_PIX_SRC_ADDR),
        .O_TA_PIX_DST_ADDR (O_TA_PIX_DST_ADDR),
        .O_TA_STORE_VALID  (O_TA_STORE_VALID),
        .I_TA_STORE_READY  (I_TA_STORE_READY),
        .O_TA_STORE_ADDR   (O_TA_STORE_ADDR),
        .O_TA_BUSY         (O_TA_BUSY),
        .O_TA_DONE         (O_TA_DONE)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge I_TA_HCLK);
        #1;
    endtask

    // Reference: turn a labelled image clockwise rot times.
    task automatic build_map(input int rot);
        int t [N][N];
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r][c] = r * N + c;
        repeat (rot) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    t[r][c] = img[N-1-c][r];
            img = t;
        end
    endtask

    function automatic logic [BPP*AW-1:0] pack3(input int base);
        logic [BPP*AW-1:0] p;
        for (int ch = 0; ch < BPP; ch++)
            p[ch*AW +: AW] = AW'(base + ch);
        return p;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_flags"},
            {O_TA_LOAD_VALID, O_TA_PIX_VALID, O_TA_STORE_VALID,
             O_TA_BUSY, O_TA_DONE}, 0);
        chk({tag, "_ls_addr"}, {O_TA_LOAD_ADDR, O_TA_STORE_ADDR}, 0);
        chk({tag, "_pix_addr"}, {O_TA_PIX_SRC_ADDR, O_TA_PIX_DST_ADDR}, 0);
    endtask

    // mode 0: always ready; 1: forced 3-cycle stalls; 2: stalls + random.
    task automatic run_tile(input logic [1:0] d, input logic dr,
                            input int mode, input int stop_at);
        int rot, cyc, lc, pc, sc, sl, sp, ss;
        bit fin, lr_v, pr_v, sr_v, plv, ppv, psv, plr, ppr, psr;
        logic [AW-1:0] pla, psa;
        logic [BPP*AW-1:0] pps, ppd;
        rot = dr ? int'(d) : (4 - int'(d)) % 4;
        build_map(rot);
        {cyc, lc, pc, sc, sl, sp, ss} = '0;
        {fin, plv, ppv, psv, plr, ppr, psr} = '0;
        pla = '0; psa = '0; pps = '0; ppd = '0;
        I_TA_DEGREES   = d;
        I_TA_DIRECTION = dr;
        I_TA_START     = 1'b1;
        while (!fin && cyc < 1000) begin
            step();
            cyc++;
            if (cyc == 1) begin
                I_TA_START = 1'b0;
                chk("start_busy", O_TA_BUSY, 1);
                chk("start_load", {O_TA_LOAD_VALID, O_TA_LOAD_ADDR},
                    {1'b1, 8'd0});
            end
            if (cyc == 30) begin
                I_TA_START     = 1'b1;
                I_TA_DEGREES   = 2'($urandom);
                I_TA_DIRECTION = 1'($urandom);
            end
            if (cyc == 31) I_TA_START = 1'b0;
            if (plv && !plr)
                chk("load_hold", {O_TA_LOAD_VALID, O_TA_LOAD_ADDR},
                    {1'b1, pla});
            if (ppv && !ppr) begin
                chk("pix_hold_v", O_TA_PIX_VALID, 1);
                chk("pix_hold_a", {O_TA_PIX_SRC_ADDR, O_TA_PIX_DST_ADDR},
                    {pps, ppd});
            end
            if (psv && !psr)
                chk("store_hold", {O_TA_STORE_VALID, O_TA_STORE_ADDR},
                    {1'b1, psa});
            chk("one_valid", (int'(O_TA_LOAD_VALID) + int'(O_TA_PIX_VALID)
                + int'(O_TA_STORE_VALID)) <= 1, 1);
            if (O_TA_DONE) begin
                chk("done_loads", lc, BEATS);
                chk("done_pixels", pc, NPIX);
                chk("done_stores", sc, BEATS);
                chk("done_busy", O_TA_BUSY, 0);
                if (mode == 0) chk("done_cycle", cyc, 161);
                fin = 1'b1;
            end else begin
                lr_v = 1'b1; pr_v = 1'b1; sr_v = 1'b1;
                if (mode != 0) begin
                    if (lc == 5 && sl < 3) begin lr_v = 1'b0; sl++; end
                    else if (mode == 2) lr_v = ($urandom_range(0, 3) != 0);
                    if (pc == 5 && sp < 3) begin pr_v = 1'b0; sp++; end
                    else if (mode == 2) pr_v = ($urandom_range(0, 3) != 0);
                    if (sc == 5 && ss < 3) begin sr_v = 1'b0; ss++; end
                    else if (mode == 2) sr_v = ($urandom_range(0, 3) != 0);
                end
                if (stop_at >= 0 && O_TA_PIX_VALID && pc == stop_at) begin
                    pr_v = 1'b1;
                    I_TA_STOP = 1'b1;
                end
                I_TA_LOAD_READY  = lr_v;
                I_TA_PIX_READY   = pr_v;
                I_TA_STORE_READY = sr_v;
                if (O_TA_LOAD_VALID && lr_v) begin
                    chk("load_addr", O_TA_LOAD_ADDR, lc * BUS);
                    lc++;
                end
                if (O_TA_PIX_VALID && pr_v) begin
                    chk("pix_src", O_TA_PIX_SRC_ADDR,
                        pack3(img[pc/N][pc%N] * BPP));
                    chk("pix_dst", O_TA_PIX_DST_ADDR, pack3(pc * BPP));
                    first_src[pc] = int'(O_TA_PIX_SRC_ADDR[AW-1:0]);
                    pc++;
                end
                if (O_TA_STORE_VALID && sr_v) begin
                    chk("store_addr", O_TA_STORE_ADDR, sc * BUS);
                    sc++;
                end
                plv = O_TA_LOAD_VALID;  plr = lr_v; pla = O_TA_LOAD_ADDR;
                ppv = O_TA_PIX_VALID;   ppr = pr_v;
                pps = O_TA_PIX_SRC_ADDR; ppd = O_TA_PIX_DST_ADDR;
                psv = O_TA_STORE_VALID; psr = sr_v; psa = O_TA_STORE_ADDR;
                if (I_TA_STOP) begin
                    step();
                    I_TA_STOP = 1'b0;
                    check_idle("stop");
                    fin = 1'b1;
                end
            end
        end
        chk("tile_finished", fin, 1);
    endtask

    initial begin
        I_TA_HRESET_N    = 1'b0;
        I_TA_START       = 1'b0;
        I_TA_STOP        = 1'b0;
        I_TA_DEGREES     = 2'd0;
        I_TA_DIRECTION   = 1'b1;
        I_TA_LOAD_READY  = 1'b1;
        I_TA_PIX_READY   = 1'b1;
        I_TA_STORE_READY = 1'b1;
        repeat (2) step();
        check_idle("reset");
        I_TA_HRESET_N = 1'b1;
        step();

        run_tile(2'd0, 1'b1, 0, -1);
        run_tile(2'd1, 1'b1, 0, -1);
        chk("cw90_p0", first_src[0], 168);
        chk("cw90_p1", first_src[1], 144);
        chk("cw90_p8", first_src[8], 171);

        run_tile(2'd1, 1'b0, 1, -1);
        chk("ccw90_p0", first_src[0], 21);

        run_tile(2'd2, 1'b1, 2, -1);
        chk("r180_p0", first_src[0], 189);
        chk("r180_p63", first_src[63], 0);

        run_tile(2'd0, 1'b1, 2, 20);
        run_tile(2'd3, 1'b0, 2, -1);
        chk("after_stop_p0", first_src[0], 168);

        I_TA_LOAD_READY = 1'b1;
        I_TA_DEGREES    = 2'd0;
        I_TA_DIRECTION  = 1'b1;
        I_TA_START      = 1'b1;
        step();
        I_TA_START = 1'b0;
        repeat (10) step();
        chk("mid_load_addr", O_TA_LOAD_ADDR, 40);
        I_TA_HRESET_N = 1'b0;
        #2;
        check_idle("rst_mid");
        #1;
        I_TA_HRESET_N = 1'b1;
        run_tile(2'd2, 1'b1, 0, -1);
        chk("after_rst_p0", first_src[0], 189);

        for (int i = 0; i < 3; i++)
            run_tile(2'($urandom), 1'($urandom), 2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
